// File: rtl/clk_prescaler_table.sv
// Programmable clock prescaler: divisor chosen from a writable register table,
// with select changes applied only at period boundaries so outputs never runt.
module clk_prescaler_table #(
    parameter int DIV_WIDTH = 24,
    parameter int SEL_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en_i,
    input  logic [SEL_WIDTH-1:0] sel_i,
    input  logic                 wr_en_i,
    input  logic [SEL_WIDTH-1:0] wr_addr_i,
    input  logic [DIV_WIDTH-1:0] wr_data_i,
    output logic                 tick_o,
    output logic                 clk_div_o,
    output logic [SEL_WIDTH-1:0] cur_sel_o,
    output logic                 sel_ack_o
);

    localparam int DEPTH = 2 ** SEL_WIDTH;

    logic [DIV_WIDTH-1:0] div_table [DEPTH];
    logic [DIV_WIDTH-1:0] act_div;
    logic [DIV_WIDTH-1:0] cnt;
    logic [DIV_WIDTH-1:0] n_eff;
    logic [DIV_WIDTH-1:0] n_last;
    logic                 terminal;
    logic                 reload;

    // A stored divisor of 0 behaves like 1 so the counter always has a valid terminal value.
    always_comb begin
        n_eff    = (act_div == '0) ? DIV_WIDTH'(1) : act_div;
        n_last   = n_eff - DIV_WIDTH'(1);
        terminal = en_i && (cnt == n_last);
        reload   = !en_i || terminal;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                div_table[i] <= DIV_WIDTH'(i + 1);
            end
        end else if (wr_en_i) begin
            div_table[wr_addr_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            tick_o    <= 1'b0;
            clk_div_o <= 1'b0;
        end else if (!en_i) begin
            cnt       <= '0;
            tick_o    <= 1'b0;
            clk_div_o <= 1'b0;
        end else if (terminal) begin
            cnt       <= '0;
            tick_o    <= 1'b1;
            clk_div_o <= ~clk_div_o;
        end else begin
            cnt       <= cnt + DIV_WIDTH'(1);
            tick_o    <= 1'b0;
        end
    end

    // The table read here sees the pre-write value when the same entry is written this edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_div   <= DIV_WIDTH'(1);
            cur_sel_o <= '0;
            sel_ack_o <= 1'b0;
        end else if (reload) begin
            act_div   <= div_table[sel_i];
            cur_sel_o <= sel_i;
            sel_ack_o <= (sel_i != cur_sel_o);
        end else begin
            sel_ack_o <= 1'b0;
        end
    end

endmodule

// File: doc/clk_prescaler_table.md
CLK_PRESCALER_TABLE -- requirements
Module: clk_prescaler_table

Interface
Parameters (name, default, meaning):
REQ-001 DIV_WIDTH, 24, width of each divisor entry and of the internal counter.
REQ-002 SEL_WIDTH, 4, select/address width; table depth = 2**SEL_WIDTH entries.

Ports (name, direction, width, meaning):
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous and active-low.
REQ-005 en_i  in  1  count enable.
REQ-006 sel_i  in  SEL_WIDTH  requested table entry.
REQ-007 wr_en_i  in  1  table write strobe.
REQ-008 wr_addr_i  in  SEL_WIDTH  table write address.
REQ-009 wr_data_i  in  DIV_WIDTH  table write data.
REQ-010 tick_o  out  1  registered one-cycle clock-enable pulse, once per divided period.
REQ-011 clk_div_o  out  1  registered divided clock; toggles on every tick, giving period 2*N and 50% duty.
REQ-012 cur_sel_o  out  SEL_WIDTH  entry currently governing the count.
REQ-013 sel_ack_o  out  1  registered one-cycle pulse when cur_sel_o changes.

Function
REQ-014 Table: 2**SEL_WIDTH x DIV_WIDTH registers; entry i reset value = i+1, truncated to DIV_WIDTH.
REQ-015 Write: wr_en_i=1 writes wr_data_i to entry wr_addr_i at the edge; writes are accepted regardless of en_i.
REQ-016 Active divisor: internal register act_div, loaded from table[sel_i] at a reload point; effective divisor N = max(act_div, 1), so 0 and 1 both mean every cycle.
REQ-017 Reload points: (a) every edge with en_i=0; (b) the terminal-count edge with en_i=1; no other edge changes act_div or cur_sel_o.
REQ-018 At a reload point: act_div <= table[sel_i] (pre-write value if the same entry is written at that edge); cur_sel_o <= sel_i; sel_ack_o <= 1 for one cycle only if the new sel_i differs from the old cur_sel_o.
REQ-019 Counter cnt (DIV_WIDTH bits): with en_i=1, if cnt == N-1 it wraps to 0 (terminal count), otherwise it increments; no overflow is possible since cnt < N <= 2**DIV_WIDTH-1.
REQ-020 At a terminal-count edge: tick_o <= 1 and clk_div_o <= ~clk_div_o; at every other edge tick_o <= 0.
REQ-021 en_i=0: cnt <= 0, tick_o <= 0, clk_div_o <= 0 at the edge.
REQ-022 Latency: with en_i first sampled 1 at edge E0 and N constant, tick_o is high in the cycles after edges E0+N-1, E0+2N-1, and so on; the period is exactly N cycles.
REQ-023 Select changes while en_i=1 take effect only at the next terminal count; the current period always completes with the old N, so there are no runt pulses on clk_div_o or tick_o.
REQ-024 A write to the active entry takes effect at the next terminal count, not mid-period.
REQ-025 sel_i changing several times within one period: only the value present at the terminal-count edge is used.
REQ-026 N=1: tick_o stays continuously high while enabled; clk_div_o toggles every cycle.

Reset
REQ-027 rst_n low, asynchronously and at any time including mid-period, sets: cnt=0, act_div=1, cur_sel_o=0, tick_o=0, clk_div_o=0, sel_ack_o=0, and the table to its REQ-014 values.
REQ-028 After rst_n deasserts, the first edge behaves per REQ-017/REQ-021; no state survives reset.

Verification
REQ-029 Reset, sel_i=3, en_i=0 for 2 cycles, then en_i=1 -> cur_sel_o=3 with sel_ack_o pulsed once while disabled; tick_o every 4 cycles; clk_div_o period 8 cycles.
REQ-030 sel_i=1 (N=2) running, sel_i changes to 7 mid-period -> the current 2-cycle period completes; subsequent ticks are 8 cycles apart; sel_ack_o pulses once at the terminal count.
REQ-031 Write entry 5 = 0 and entry 6 = 0xFFFFFF via the write port, then select 5 -> tick_o is continuously high; select 6 with DIV_WIDTH=24 -> one tick per 16777215 cycles (check by counter peek or a reduced-DIV_WIDTH build).
REQ-032 While running on entry 2 (N=3), write entry 2 = 10 at cnt=1 -> the current period stays 3 cycles; the next period is 10 cycles.
REQ-033 Assert rst_n low asynchronously (between clock edges) at cnt=2 -> all outputs are 0 immediately; after release with en_i=1, the first tick occurs N cycles later with N = entry0 = 1.
REQ-034 Drop en_i for 1 cycle mid-period -> cnt, tick_o and clk_div_o go to 0; on re-enable the period restarts from 0 with a full N cycles.
